// File: rtl/sub_bytes_serial.sv
// Serial AES SubBytes/InvSubBytes engine: BYTES_PER_CYCLE shared sbox instances walk a latched 128-bit state.
// Define SUB_BYTES_SHIFTROWS_FUSE_EN to fold ShiftRows/InvShiftRows into the result write-back addressing.

module sbox (
   input  logic [7:0] in_i,
   input  logic       sel_i,
   output logic [7:0] out_o
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] t;
      t = {x, x};
      return t[15-n -: 8];
   endfunction

   logic [7:0] pre;
   logic [7:0] inv_v;

   always_comb begin
      pre   = sel_i ? (rotl(in_i, 1) ^ rotl(in_i, 3) ^ rotl(in_i, 6) ^ 8'h05) : in_i;
      inv_v = gf_inv(pre);
      out_o = sel_i ? inv_v
                    : (inv_v ^ rotl(inv_v, 1) ^ rotl(inv_v, 2) ^ rotl(inv_v, 3) ^ rotl(inv_v, 4) ^ 8'h63);
   end
endmodule

// state | meaning
// IDLE  | waiting for a state, in_ready high
// RUN   | substituting BYTES_PER_CYCLE bytes per cycle
// DONE  | result presented, waiting for out_ready
module sub_bytes_serial #(
   parameter int unsigned BYTES_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_sel,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);
   localparam int unsigned NSTEP = 16 / BYTES_PER_CYCLE;
   localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [127:0]   data_q, data_d;
   logic [127:0]   res_q, res_d;
   logic           sel_q, sel_d;

   logic [3:0] src_idx [BYTES_PER_CYCLE];
   logic [3:0] dst_idx [BYTES_PER_CYCLE];
   logic [7:0] sb_in   [BYTES_PER_CYCLE];
   logic [7:0] sb_out  [BYTES_PER_CYCLE];

   // byte index = 4*col + row, so [3:2] is the column and [1:0] the row
   always_comb begin
      for (int j = 0; j < int'(BYTES_PER_CYCLE); j++) begin
         src_idx[j] = 4'((int'(cnt_q) * int'(BYTES_PER_CYCLE)) + j);
         sb_in[j]   = data_q[8*(15-int'(src_idx[j])) +: 8];
`ifdef SUB_BYTES_SHIFTROWS_FUSE_EN
         dst_idx[j] = sel_q ? {src_idx[j][3:2] + src_idx[j][1:0], src_idx[j][1:0]}
                            : {src_idx[j][3:2] - src_idx[j][1:0], src_idx[j][1:0]};
`else
         dst_idx[j] = src_idx[j];
`endif
      end
   end

   for (genvar g = 0; g < int'(BYTES_PER_CYCLE); g++) begin : g_sbox
      sbox u_sbox (
         .in_i  (sb_in[g]),
         .sel_i (sel_q),
         .out_o (sb_out[g])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      sel_d   = sel_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               sel_d   = in_sel;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int j = 0; j < int'(BYTES_PER_CYCLE); j++)
               res_d[8*(15-int'(dst_idx[j])) +: 8] = sb_out[j];
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         sel_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         res_q   <= res_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign out_data  = res_q;
endmodule
